vfpu_wb_ctrl: RTL and testbench

//  Writeback stage directly downstream of the vector FPU. Issues a destination tag alongside each op sent
//  to the FPU and delays the tag to match the FPU pipeline. Captures the FPU result vector when the tag

---
 rtl/vfpu_pkg.sv | 32 +++
 rtl/vfpu_wb_fifo.sv | 74 +++++++
 rtl/vfpu_wb_ctrl.sv | 97 +++++++++
 tb/tb_vfpu_wb_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vfpu_pkg : shared types for the vector FPU writeback stage               |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package vfpu_pkg;

  localparam int SIG_WIDTH    = 23;
  localparam int EXP_WIDTH    = 8;
  localparam int VECTOR_LANES = 16;
  localparam int DATA_WIDTH   = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int ADDR_WIDTH   = 5;

  typedef logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
  } wb_tag_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    lane_vec_t             data;
  } wb_entry_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vfpu_wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vfpu_wb_fifo : circular synchronous FIFO with occupancy count            |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module vfpu_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // Zero the head when empty so the consumer sees clean data out of reset.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule
`default_nettype wire

// File: rtl/vfpu_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vfpu_wb_ctrl : tags FPU ops, captures matured results, buffers them and  |
// |                drains to the vector register file under issue credit    |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module vfpu_wb_ctrl
  import vfpu_pkg::*;
#(
  parameter int SIG_WIDTH    = 23,
  parameter int EXP_WIDTH    = 8,
  parameter int VECTOR_LANES = 16,
  parameter int NUM_STAGES   = 3,
  parameter int DATA_WIDTH   = SIG_WIDTH + EXP_WIDTH + 1,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic                                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]                    issue_rd,
  output logic                                     issue_ready,
  input  logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]  fpu_out,
  output logic                                     wb_valid,
  input  logic                                     wb_ready,
  output logic [ADDR_WIDTH-1:0]                    wb_addr,
  output logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]  wb_data,
  output logic                                     idle
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int INF_W = cnt_width(NUM_STAGES);

  wb_tag_t [NUM_STAGES-1:0] tag_q, tag_d;
  logic    [INF_W-1:0]      inflight_q, inflight_d;
  logic    [CNT_W-1:0]      fifo_count;
  logic                     fifo_empty;
  logic                     accept, capture;
  wb_entry_t                push_entry, head_entry;

  always_comb begin
    // Credit looks only at registered occupancy, keeping wb_ready off this path.
    issue_ready = (int'(inflight_q) + int'(fifo_count)) < FIFO_DEPTH;
    accept      = issue_valid & issue_ready & en;
    capture     = en & tag_q[NUM_STAGES-1].valid;

    tag_d = tag_q;
    if (en) begin
      tag_d[0] = {accept, issue_rd};
      for (int i = 1; i < NUM_STAGES; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end

    inflight_d = inflight_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    push_entry = {tag_q[NUM_STAGES-1].rd, fpu_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  vfpu_wb_fifo #(
    .WIDTH (($bits(wb_entry_t))),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_entry),
    .pop       (wb_ready),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wb_valid = ~fifo_empty;
  assign wb_addr  = head_entry.rd;
  assign wb_data  = head_entry.data;
  assign idle     = (inflight_q == '0) & fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_vfpu_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vfpu_wb_ctrl : randomized bench for the FPU writeback stage           |
// | Rev 1.0         : initial release                                        |
// +--------------------------------------------------------------------------+
module tb_vfpu_wb_ctrl;
  import vfpu_pkg::*;

  localparam int NS = 3;
  localparam int FD = 4;
  localparam int AW = 5;
  localparam int VL = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_ready;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic          idle;
  lane_vec_t     fpu_in = '0;
  lane_vec_t     fpu_out;
  lane_vec_t     wb_data;
  lane_vec_t     fpu_pipe [NS] = '{default: '0};

  int errors = 0;
  int checks = 0;

  // Reference model: ops awaiting maturity (age = en-edges seen) and results ready to drain.
  typedef struct {
    logic [AW-1:0] rd;
    lane_vec_t     data;
    int            age;
  } op_t;
  op_t pend[$];
  op_t rq[$];

  always #5 clk = ~clk;

  // FPU stand-in: en-gated delay line of NS stages.
  always @(posedge clk) begin
    if (en) begin
      for (int i = NS - 1; i > 0; i--) fpu_pipe[i] <= fpu_pipe[i-1];
      fpu_pipe[0] <= fpu_in;
    end
  end
  assign fpu_out = fpu_pipe[NS-1];

  vfpu_wb_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .fpu_out     (fpu_out),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .idle        (idle)
  );

  function automatic lane_vec_t rand_vec();
    lane_vec_t v;
    for (int i = 0; i < VL; i++) v[i] = $urandom;
    return v;
  endfunction

  function automatic bit m_ready();
    return (pend.size() + rq.size()) < FD;
  endfunction

  function automatic bit m_idle();
    return (pend.size() == 0) && (rq.size() == 0);
  endfunction

  // Apply inputs just after an edge, then wait to the mid-cycle sample point.
  task automatic drive(input logic e, input logic v, input logic [AW-1:0] r, input logic w);
    en = e; issue_valid = v; issue_rd = r; wb_ready = w; fpu_in = rand_vec();
    #4;
  endtask

  // Cross the next edge and advance the reference model.
  task automatic advance();
    logic acc, pop;
    op_t  n;
    acc    = en && issue_valid && m_ready();
    pop    = wb_ready && (rq.size() != 0);
    n.rd   = issue_rd;
    n.data = fpu_in;
    n.age  = 1;
    @(posedge clk);
    if (!rst_n) begin
      pend.delete(); rq.delete();
    end else begin
      if (pop) void'(rq.pop_front());
      if (en) begin
        foreach (pend[i]) pend[i].age = pend[i].age + 1;
        if (acc) pend.push_back(n);
        while (pend.size() != 0 && pend[0].age > NS) rq.push_back(pend.pop_front());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; issue_valid = 1'b0; wb_ready = 1'b0; issue_rd = '0;
    pend.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_addr !== '0) begin errors++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    rst_n = 1'b1;
    #4;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int        first;
    lane_vec_t d;
    first = -1;
    drive(1'b1, 1'b1, 5'd7, 1'b1);
    d = fpu_in;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", issue_ready); end
    advance();
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1);
      if (wb_valid === 1'b1 && first < 0) begin
        first = c;
        checks++; if (wb_addr !== 5'd7) begin errors++; $display("FAIL single_addr: got %0d want 7", wb_addr); end
        checks++; if (wb_data !== d) begin errors++; $display("FAIL single_data: got %h want %h", wb_data, d); end
      end
      advance();
    end
    checks++; if (first != 4) begin errors++; $display("FAIL single_latency: got cycle %0d want 4", first); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", idle); end
  endtask

  task automatic test_back_to_back();
    int popped;
    popped = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0);
      checks++; if (issue_ready !== (i < 4)) begin errors++; $display("FAIL b2b_credit[%0d]: got %b want %b", i, issue_ready, (i < 4)); end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b0);
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_credit: got %b want 0", issue_ready); end
      advance();
    end
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd0) begin errors++; $display("FAIL b2b_head: got valid=%b addr=%0d want valid=1 addr=0", wb_valid, wb_addr); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1);
      if (wb_valid === 1'b1) begin
        checks++; if (wb_addr !== 5'(popped)) begin errors++; $display("FAIL b2b_order: got %0d want %0d", wb_addr, popped); end
        if (rq.size() != 0) begin
          checks++; if (wb_data !== rq[0].data) begin errors++; $display("FAIL b2b_data: got %h want %h", wb_data, rq[0].data); end
        end
        popped++;
      end
      advance();
    end
    checks++; if (popped != 4) begin errors++; $display("FAIL b2b_pop_count: got %0d want 4", popped); end
    checks++; if (issue_ready !== 1'b1 || idle !== 1'b1) begin errors++; $display("FAIL b2b_recover: got ready=%b idle=%b want 1 1", issue_ready, idle); end
  endtask

  task automatic test_en_stall();
    int first, pops;
    first = -1; pops = 0;
    for (int c = 0; c < 16; c++) begin
      drive((c < 3 || c >= 8), (c == 0), 5'd3, (c >= 11));
      checks++; if (wb_valid !== (rq.size() != 0)) begin errors++; $display("FAIL stall_valid[%0d]: got %b want %b", c, wb_valid, (rq.size() != 0)); end
      if (wb_valid === 1'b1 && first < 0) begin
        first = c;
        checks++; if (wb_addr !== 5'd3) begin errors++; $display("FAIL stall_addr: got %0d want 3", wb_addr); end
      end
      if (wb_valid === 1'b1 && wb_ready) pops++;
      advance();
    end
    checks++; if (first != 9) begin errors++; $display("FAIL stall_latency: got cycle %0d want 9", first); end
    checks++; if (pops != 1) begin errors++; $display("FAIL stall_single_capture: got %0d pops want 1", pops); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stall_idle: got %b want 1", idle); end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, (c < 20), 5'(c), (c >= 6));
      checks++; if (issue_ready !== m_ready()) begin errors++; $display("FAIL stream_credit[%0d]: got %b want %b", c, issue_ready, m_ready()); end
      checks++; if (wb_valid !== (rq.size() != 0)) begin errors++; $display("FAIL stream_valid[%0d]: got %b want %b", c, wb_valid, (rq.size() != 0)); end
      if (rq.size() != 0) begin
        checks++; if (wb_addr !== rq[0].rd || wb_data !== rq[0].data) begin errors++; $display("FAIL stream_head[%0d]: got addr=%0d want %0d", c, wb_addr, rq[0].rd); end
      end
      advance();
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stream_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, (c < 4), 5'(16 + c), 1'b0);
      advance();
    end
    drive(1'b1, 1'b0, 5'd0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd16 || idle !== 1'b0) begin errors++; $display("FAIL midop_pre: got valid=%b addr=%0d idle=%b want 1 16 0", wb_valid, wb_addr, idle); end
    rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || wb_data !== '0) begin errors++; $display("FAIL midop_reset_out: got valid=%b data=%h want 0", wb_valid, wb_data); end
    checks++; if (idle !== 1'b1 || issue_ready !== 1'b1) begin errors++; $display("FAIL midop_reset_state: got idle=%b ready=%b want 1 1", idle, issue_ready); end
    advance();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b0, 5'd0, 1'b1);
      checks++; if (wb_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL midop_stale[%0d]: got valid=%b idle=%b want 0 1", c, wb_valid, idle); end
      advance();
    end
  endtask

  task automatic test_wrap();
    int   acc, popped, c;
    logic e, v, w;
    acc = 0; popped = 0; c = 0;
    while (popped < 20 && c < 600) begin
      e = ($urandom_range(0, 3) != 0);
      v = (acc < 20) && ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 2) != 0);
      drive(e, v, 5'($urandom), w);
      checks++; if (issue_ready !== m_ready()) begin errors++; $display("FAIL wrap_credit[%0d]: got %b want %b", c, issue_ready, m_ready()); end
      checks++; if (wb_valid !== (rq.size() != 0)) begin errors++; $display("FAIL wrap_valid[%0d]: got %b want %b", c, wb_valid, (rq.size() != 0)); end
      checks++; if (idle !== m_idle()) begin errors++; $display("FAIL wrap_idle[%0d]: got %b want %b", c, idle, m_idle()); end
      if (rq.size() != 0) begin
        checks++; if (wb_addr !== rq[0].rd) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", c, wb_addr, rq[0].rd); end
        checks++; if (wb_data !== rq[0].data) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", c, wb_data, rq[0].data); end
      end
      if (e && v && m_ready()) acc++;
      if (w && rq.size() != 0) popped++;
      advance();
      c++;
    end
    checks++; if (popped != 20) begin errors++; $display("FAIL wrap_timeout: got %0d results want 20", popped); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_en_stall();
    test_stream();
    test_reset_midop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
